// File: rtl/lfsr_match_counter.sv
// lfsr_match_counter: Fibonacci LFSR stepped from a seed until it hits a captured target, with timeout, lock-up and auto-reload
// Ports: clk/rst (sync, active-high); load/load_val force the LFSR; start arms a run and samples target;
// stop aborts; en gates stepping; lfsr_out/steps/busy/done/timeout/lockup are all registered state.
module lfsr_match_counter #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
  parameter logic [WIDTH-1:0] SEED        = '1,
  parameter bit               AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] lfsr_out,
  output logic [WIDTH-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             lockup
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q;
  logic [WIDTH-1:0] lfsr_q, steps_q, target_q, nxt, steps_inc;
  logic timeout_q, lockup_q, arm;
  assign nxt = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign steps_inc = steps_q + WIDTH'(1);
  assign arm = start && !lockup_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= SEED;
      steps_q   <= '0;
      target_q  <= '0;
      timeout_q <= 1'b0;
      lockup_q  <= 1'b0;
      state_q   <= IDLE;
    end else if (load) begin
      lfsr_q    <= load_val;
      steps_q   <= '0;
      timeout_q <= 1'b0;
      lockup_q  <= (load_val == '0);
      state_q   <= IDLE;
    end else if (stop) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        RUN: if (en) begin
          lfsr_q  <= nxt;
          steps_q <= steps_inc;
          if (nxt == target_q) state_q <= DONE;
          else if (steps_inc == '1) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
          end
        end
        DONE: if (AUTO_RELOAD) begin
          lfsr_q    <= SEED;
          steps_q   <= '0;
          timeout_q <= 1'b0;
          state_q   <= RUN;
        end else if (arm) begin
          target_q  <= target;
          steps_q   <= '0;
          timeout_q <= 1'b0;
          state_q   <= (lfsr_q == target) ? DONE : RUN;
        end
        default: if (arm) begin
          target_q  <= target;
          steps_q   <= '0;
          timeout_q <= 1'b0;
          state_q   <= (lfsr_q == target) ? DONE : RUN;
        end
      endcase
    end
  end
  assign lfsr_out = lfsr_q;
  assign steps    = steps_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign timeout  = timeout_q;
  assign lockup   = lockup_q;
endmodule

// File: tb/tb_lfsr_match_counter.sv
// tb_lfsr_match_counter: scoreboard bench for one-shot, auto-reload and 8-bit LFSR match counters
module tb_lfsr_match_counter;
  logic clk = 1'b0;
  logic rst, load, start, stop, en;
  logic [3:0] load_val4, target4;
  logic [7:0] load_val8, target8;
  logic [3:0] lo_a, st_a, lo_b, st_b;
  logic [7:0] lo_c, st_c;
  logic busy_a, done_a, to_a, lk_a;
  logic busy_b, done_b, to_b, lk_b;
  logic busy_c, done_c, to_c, lk_c;
  int errors = 0;
  int checks = 0;
  logic [11:0] q4[$];
  logic [19:0] q8[$];
  always #5 clk = ~clk;
  lfsr_match_counter dut_a (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val4), .start(start), .stop(stop), .en(en),
    .target(target4), .lfsr_out(lo_a), .steps(st_a), .busy(busy_a), .done(done_a), .timeout(to_a), .lockup(lk_a)
  );
  lfsr_match_counter #(.AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val4), .start(start), .stop(stop), .en(en),
    .target(target4), .lfsr_out(lo_b), .steps(st_b), .busy(busy_b), .done(done_b), .timeout(to_b), .lockup(lk_b)
  );
  lfsr_match_counter #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hFF)) dut_c (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val8), .start(start), .stop(stop), .en(en),
    .target(target8), .lfsr_out(lo_c), .steps(st_c), .busy(busy_c), .done(done_c), .timeout(to_c), .lockup(lk_c)
  );
  function automatic logic [3:0] nxt4(input logic [3:0] v);
    return {v[2:0], ^(v & 4'b1100)};
  endfunction
  function automatic logic [7:0] nxt8(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
    load_val4 = '0; load_val8 = '0; target4 = '0; target8 = '0;
    tick;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    checks++;
    if ({lo_a, st_a, busy_a, done_a, to_a, lk_a} !== {4'hF, 4'h0, 4'b0000}) begin
      errors++; $display("FAIL reset_a: got %h want %h", {lo_a, st_a, busy_a, done_a, to_a, lk_a}, {4'hF, 4'h0, 4'b0000});
    end
    checks++;
    if ({lo_c, st_c, busy_c, done_c, to_c, lk_c} !== {8'hFF, 8'h00, 4'b0000}) begin
      errors++; $display("FAIL reset_c: got %h want %h", {lo_c, st_c, busy_c, done_c, to_c, lk_c}, {8'hFF, 8'h00, 4'b0000});
    end
  endtask
  task automatic test_basic;
    logic [3:0] v;
    logic [11:0] e;
    do_reset;
    target4 = 4'b0001;
    v = 4'hF;
    q4.push_back({v, 4'd0, 4'b1000});
    for (int i = 1; i <= 4; i++) begin
      v = nxt4(v);
      q4.push_back({v, 4'(i), (i < 4), (i == 4), 2'b00});
    end
    for (int i = 0; i < 3; i++) q4.push_back({v, 4'd4, 4'b0100});
    start = 1'b1; en = 1'b1;
    while (q4.size() > 0) begin
      tick;
      start = 1'b0;
      e = q4.pop_front();
      checks++;
      if ({lo_a, st_a, busy_a, done_a, to_a, lk_a} !== e) begin
        errors++; $display("FAIL basic_seq: got %h want %h", {lo_a, st_a, busy_a, done_a, to_a, lk_a}, e);
      end
    end
    checks++;
    if ({lo_a, st_a} !== {4'b0001, 4'd4}) begin
      errors++; $display("FAIL basic_final: got %h want %h", {lo_a, st_a}, {4'b0001, 4'd4});
    end
  endtask
  task automatic test_timeout;
    logic [3:0] v;
    logic [11:0] e;
    do_reset;
    target4 = 4'b0000;
    v = 4'hF;
    q4.push_back({v, 4'd0, 4'b1000});
    for (int i = 1; i <= 15; i++) begin
      v = nxt4(v);
      q4.push_back({v, 4'(i), (i < 15), (i == 15), (i == 15), 1'b0});
    end
    q4.push_back({v, 4'd15, 4'b0110});
    start = 1'b1; en = 1'b1;
    while (q4.size() > 0) begin
      tick;
      start = 1'b0;
      e = q4.pop_front();
      checks++;
      if ({lo_a, st_a, busy_a, done_a, to_a, lk_a} !== e) begin
        errors++; $display("FAIL timeout_seq: got %h want %h", {lo_a, st_a, busy_a, done_a, to_a, lk_a}, e);
      end
    end
    checks++;
    if ({lo_a, st_a, to_a, done_a} !== {4'hF, 4'd15, 2'b11}) begin
      errors++; $display("FAIL timeout_final: got %h want %h", {lo_a, st_a, to_a, done_a}, {4'hF, 4'd15, 2'b11});
    end
  endtask
  task automatic test_lockup;
    logic [3:0] v;
    logic [11:0] e;
    do_reset;
    load = 1'b1; load_val4 = 4'h0;
    tick;
    load = 1'b0;
    checks++;
    if ({lo_a, lk_a} !== {4'h0, 1'b1}) begin
      errors++; $display("FAIL lockup_set: got %h want %h", {lo_a, lk_a}, {4'h0, 1'b1});
    end
    start = 1'b1; target4 = 4'b0001; en = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      errors++; $display("FAIL lockup_start: got %b want %b", {busy_a, done_a}, 2'b00);
    end
    load = 1'b1; load_val4 = 4'b1001;
    tick;
    load = 1'b0;
    checks++;
    if ({lo_a, lk_a} !== {4'b1001, 1'b0}) begin
      errors++; $display("FAIL lockup_clear: got %h want %h", {lo_a, lk_a}, {4'b1001, 1'b0});
    end
    v = 4'b1001;
    q4.push_back({v, 4'd0, 4'b1000});
    for (int i = 1; i <= 2; i++) begin
      v = nxt4(v);
      q4.push_back({v, 4'(i), (i < 2), (i == 2), 2'b00});
    end
    start = 1'b1; target4 = 4'b0110;
    while (q4.size() > 0) begin
      tick;
      start = 1'b0;
      e = q4.pop_front();
      checks++;
      if ({lo_a, st_a, busy_a, done_a, to_a, lk_a} !== e) begin
        errors++; $display("FAIL lockup_run: got %h want %h", {lo_a, st_a, busy_a, done_a, to_a, lk_a}, e);
      end
    end
    checks++;
    if ({lo_a, st_a, done_a} !== {4'b0110, 4'd2, 1'b1}) begin
      errors++; $display("FAIL lockup_final: got %h want %h", {lo_a, st_a, done_a}, {4'b0110, 4'd2, 1'b1});
    end
  endtask
  task automatic test_en_toggle;
    logic [3:0] v, s;
    logic [11:0] e;
    logic [4:0] pat;
    do_reset;
    target4 = 4'b1000; start = 1'b1; en = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if ({busy_a, st_a, lo_a} !== {1'b1, 4'd0, 4'hF}) begin
      errors++; $display("FAIL en_start: got %h want %h", {busy_a, st_a, lo_a}, {1'b1, 4'd0, 4'hF});
    end
    pat = 5'b10101;
    v = 4'hF; s = 4'd0;
    for (int k = 0; k < 5; k++) begin
      en = pat[k];
      if (pat[k]) begin
        v = nxt4(v);
        s = s + 4'd1;
      end
      q4.push_back({v, s, (v != 4'b1000), (v == 4'b1000), 2'b00});
      tick;
      e = q4.pop_front();
      checks++;
      if ({lo_a, st_a, busy_a, done_a, to_a, lk_a} !== e) begin
        errors++; $display("FAIL en_toggle: got %h want %h", {lo_a, st_a, busy_a, done_a, to_a, lk_a}, e);
      end
    end
  endtask
  task automatic test_stop;
    do_reset;
    target4 = 4'b1000; start = 1'b1; en = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checks++;
    if ({lo_a, st_a, busy_a, done_a} !== {4'b1100, 4'd2, 2'b00}) begin
      errors++; $display("FAIL stop_idle: got %h want %h", {lo_a, st_a, busy_a, done_a}, {4'b1100, 4'd2, 2'b00});
    end
    tick;
    tick;
    checks++;
    if ({lo_a, st_a, busy_a, done_a} !== {4'b1100, 4'd2, 2'b00}) begin
      errors++; $display("FAIL stop_hold: got %h want %h", {lo_a, st_a, busy_a, done_a}, {4'b1100, 4'd2, 2'b00});
    end
  endtask
  task automatic test_load_start;
    do_reset;
    load = 1'b1; load_val4 = 4'b0101; start = 1'b1; target4 = 4'b0101; en = 1'b1;
    tick;
    load = 1'b0; start = 1'b0;
    checks++;
    if ({lo_a, st_a, busy_a, done_a, to_a, lk_a} !== {4'b0101, 4'd0, 4'b0000}) begin
      errors++; $display("FAIL load_start: got %h want %h", {lo_a, st_a, busy_a, done_a, to_a, lk_a}, {4'b0101, 4'd0, 4'b0000});
    end
    tick;
    checks++;
    if ({lo_a, busy_a, done_a} !== {4'b0101, 2'b00}) begin
      errors++; $display("FAIL load_start_hold: got %h want %h", {lo_a, busy_a, done_a}, {4'b0101, 2'b00});
    end
  endtask
  task automatic test_auto_reload;
    logic [3:0] v, s;
    logic d;
    logic [11:0] e;
    int pulses;
    do_reset;
    target4 = 4'b1000;
    v = 4'hF; s = 4'd0; d = 1'b0; pulses = 0;
    q4.push_back({v, s, 4'b1000});
    for (int k = 1; k <= 12; k++) begin
      if (d) begin
        v = 4'hF; s = 4'd0; d = 1'b0;
      end else begin
        v = nxt4(v); s = s + 4'd1; d = (v == 4'b1000);
      end
      q4.push_back({v, s, !d, d, 2'b00});
    end
    start = 1'b1; en = 1'b1;
    while (q4.size() > 0) begin
      tick;
      start = 1'b0;
      if (done_b) pulses++;
      e = q4.pop_front();
      checks++;
      if ({lo_b, st_b, busy_b, done_b, to_b, lk_b} !== e) begin
        errors++; $display("FAIL auto_reload: got %h want %h", {lo_b, st_b, busy_b, done_b, to_b, lk_b}, e);
      end
    end
    checks++;
    if (pulses !== 3) begin
      errors++; $display("FAIL auto_pulses: got %0d want 3", pulses);
    end
  endtask
  task automatic test_wide;
    logic [7:0] v;
    logic [19:0] e;
    do_reset;
    target8 = 8'h00;
    v = 8'hFF;
    q8.push_back({v, 8'd0, 4'b1000});
    for (int i = 1; i <= 255; i++) begin
      v = nxt8(v);
      q8.push_back({v, 8'(i), (i < 255), (i == 255), (i == 255), 1'b0});
    end
    start = 1'b1; en = 1'b1;
    while (q8.size() > 0) begin
      tick;
      start = 1'b0;
      e = q8.pop_front();
      checks++;
      if ({lo_c, st_c, busy_c, done_c, to_c, lk_c} !== e) begin
        errors++; $display("FAIL wide_seq: got %h want %h", {lo_c, st_c, busy_c, done_c, to_c, lk_c}, e);
      end
    end
    checks++;
    if ({lo_c, st_c, to_c, done_c} !== {8'hFF, 8'd255, 2'b11}) begin
      errors++; $display("FAIL wide_final: got %h want %h", {lo_c, st_c, to_c, done_c}, {8'hFF, 8'd255, 2'b11});
    end
  endtask
  task automatic test_reset_mid;
    do_reset;
    target8 = 8'h00; start = 1'b1; en = 1'b1;
    tick;
    start = 1'b0;
    repeat (100) tick;
    checks++;
    if ({st_c, busy_c} !== {8'd100, 1'b1}) begin
      errors++; $display("FAIL mid_steps: got %h want %h", {st_c, busy_c}, {8'd100, 1'b1});
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({lo_c, st_c, busy_c, done_c, to_c, lk_c} !== {8'hFF, 8'h00, 4'b0000}) begin
      errors++; $display("FAIL mid_reset: got %h want %h", {lo_c, st_c, busy_c, done_c, to_c, lk_c}, {8'hFF, 8'h00, 4'b0000});
    end
    tick;
    checks++;
    if ({lo_c, st_c, busy_c, done_c} !== {8'hFF, 8'h00, 2'b00}) begin
      errors++; $display("FAIL mid_after: got %h want %h", {lo_c, st_c, busy_c, done_c}, {8'hFF, 8'h00, 2'b00});
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_basic;
    test_timeout;
    test_lockup;
    test_en_toggle;
    test_stop;
    test_load_start;
    test_auto_reload;
    test_wide;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
